dma_cfg_sequencer: RTL
======================

Name: dma_cfg_sequencer

Overview:
Sequences one DMA job at a time by programming the DMA's four-entry register map over its AXI write-slave port (aw/w/b), then waiting for dma_done. It sits between a job producer (CPU model or bench) and the dma_wrap w_slave0 channels, replacing hand-coded aw/w stimulus. It reports completion and B-response errors on a status channel.

Parameters:
AXI_ID, 4'h0, id field driven on every aw beat.
REG_STRIDE, 32'h80, byte distance between DMA registers; register k sits at k*REG_STRIDE.
START_VAL, 64'h1, data written to the start register (index 3).
WSTRB, 8'hFF, wstrb driven on every w beat.
TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous active-high reset.
job_dat  in  96  {len[31:0], dst[31:0], src[31:0]}.
job_vld  in  1  job valid.
job_rdy  out  1  job ready; high only in IDLE.
aw_dat  out  44  {len[7:0]=0, addr[31:0], id[3:0]=AXI_ID}, to dma w_slave0_aw.
aw_vld  out  1  write-address valid.
aw_rdy  in  1  write-address ready.
w_dat  out  73  {wstrb=WSTRB, last=1, data[63:0]}, to dma w_slave0_w.
w_vld  out  1  write-data valid.
w_rdy  in  1  write-data ready.
b_dat  in  6  {resp[1:0], id[3:0]}.
b_vld  in  1  write-response valid.
b_rdy  out  1  write-response ready.
done_dat  in  1  dma_done payload (ignored).
done_vld  in  1  dma_done valid.
done_rdy  out  1  high only in WAIT_DONE.
sts_dat  out  2  {timeout, bresp_err}.
sts_vld  out  1  status valid.
sts_rdy  in  1  status ready.
busy  out  1  high in any state other than IDLE.
job_cnt  out  16  count of completed jobs; wraps from 16'hFFFF to 0.

Behaviour:
- Reset: state=IDLE, idx=0, every vld/rdy output 0, except job_rdy=1. aw_dat, w_dat, sts_dat, job_cnt and the latched job are all 0. All outputs are registered.
- States: IDLE, AW, W, B, WAIT_DONE, STS.
- IDLE: on job_vld&&job_rdy, latch the job, set idx=0, go to AW. job_rdy drops the following cycle.
- AW: aw_vld=1 and addr=idx*REG_STRIDE. Stay until aw_vld&&aw_rdy, then deassert aw_vld and go to W.
- W: w_vld=1. data is src, dst, len or START_VAL for idx 0..3; 32-bit values are zero-extended to 64 bits. Stay until w_vld&&w_rdy, then go to B.
- Address and data beats are strictly sequential, never concurrent. vld is never dropped before its handshake completes.
- B: b_rdy=1. On b_vld, if resp!=0 set sticky bresp_err; b.id is not checked. If idx==3 go to WAIT_DONE, else idx+1 and return to AW.
- WAIT_DONE: done_rdy=1. On done_vld, go to STS.
- STS: sts_vld=1 with the sticky flags. On sts_rdy, increment job_cnt, clear the flags, go to IDLE. job_cnt increments exactly once per job.
- Minimum latency, job accept to sts_vld, with all slaves always ready: 4*3+2 = 14 cycles.
- A done_vld seen outside WAIT_DONE is not consumed (done_rdy=0) and is held by the DMA.
- Reset mid-operation: immediate return to IDLE with all handshake outputs 0. The DMA is not reset by this block.

Optional Feature:
Macro DMA_CFG_SEQ_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to WAIT_DONE. If it reaches TIMEOUT_CYC without done_vld, go to STS with timeout=1. A done_vld arriving on the same cycle as the timeout takes priority (timeout=0).
- Undefined: no counter; WAIT_DONE waits indefinitely and sts_dat[1] is tied to 0.

Decomposition:
- Shared package dma_cfg_pkg holds: the aw/w/b packed struct typedefs (44/73/6 bits, same field order as the DMA), the register-index constants (SRC=0, DST=1, LEN=2, START=3), and the state enum.
- No sub-module needed; the FSM, index counter and optional watchdog stay in one module.

Test Plan:
- Job {len=0x3F, dst=0x4000, src=0x1000}, slaves always ready: expect aw addrs 0x0/0x80/0x100/0x180 with data 0x1000/0x4000/0x3F/0x1. After done_vld, expect sts_vld with sts_dat=2'b00, job_cnt=1, total 14 cycles.
- Same job, aw_rdy held low 5 cycles on each beat: aw_vld/aw_dat stable throughout, no w_vld before the aw handshake, final result identical.
- b resp=2'b10 on the second write: the sequence continues and sts_dat=2'b01. The next job reports 2'b00.
- sts_rdy held low 10 cycles: sts_vld held, job_rdy=0, job_cnt unchanged until the handshake.
- Reset asserted during state W: all vld low and job_rdy=1 immediately. A new job then restarts from addr 0x0.
- With DMA_CFG_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, done never asserted: sts_dat=2'b10 exactly 16 cycles after entering WAIT_DONE.

Source files
------------

// File: rtl/dma_cfg_pkg.sv
// rtl/dma_cfg_pkg.sv - shared beat layouts, register indices and FSM states for dma_cfg_sequencer
package dma_cfg_pkg;

  // Write-address beat, field order matches the DMA w_slave0_aw channel (44 bits)
  typedef struct packed {
    logic [7:0]  len;
    logic [31:0] addr;
    logic [3:0]  id;
  } aw_beat_t;

  // Write-data beat, field order matches the DMA w_slave0_w channel (73 bits)
  typedef struct packed {
    logic [7:0]  wstrb;
    logic        last;
    logic [63:0] data;
  } w_beat_t;

  // Write-response beat (6 bits)
  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_beat_t;

  // Job descriptor as presented by the producer (96 bits)
  typedef struct packed {
    logic [31:0] len;
    logic [31:0] dst;
    logic [31:0] src;
  } job_t;

  // DMA register map indices, programmed in ascending order
  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DST   = 2'd1;
  localparam logic [1:0] REG_LEN   = 2'd2;
  localparam logic [1:0] REG_START = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AW        = 3'd1,
    ST_W         = 3'd2,
    ST_B         = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_STS       = 3'd5
  } seq_state_t;

  // Byte address of register idx given the register stride
  function automatic logic [31:0] reg_addr(input logic [1:0] idx, input logic [31:0] stride);
    return 32'(idx) * stride;
  endfunction

endpackage

// File: rtl/dma_cfg_sequencer.sv
// rtl/dma_cfg_sequencer.sv - programs one DMA job over aw/w/b, waits for done, reports status; optional watchdog via DMA_CFG_SEQ_TIMEOUT_EN
module dma_cfg_sequencer
  import dma_cfg_pkg::*;
#(
  parameter logic [3:0]  AXI_ID      = 4'h0,
  parameter logic [31:0] REG_STRIDE  = 32'h80,
  parameter logic [63:0] START_VAL   = 64'h1,
  parameter logic [7:0]  WSTRB       = 8'hFF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [95:0] i_job_dat,
  input  logic        i_job_vld,
  output logic        o_job_rdy,
  output logic [43:0] o_aw_dat,
  output logic        o_aw_vld,
  input  logic        i_aw_rdy,
  output logic [72:0] o_w_dat,
  output logic        o_w_vld,
  input  logic        i_w_rdy,
  input  logic [5:0]  i_b_dat,
  input  logic        i_b_vld,
  output logic        o_b_rdy,
  input  logic        i_done_dat,
  input  logic        i_done_vld,
  output logic        o_done_rdy,
  output logic [1:0]  o_sts_dat,
  output logic        o_sts_vld,
  input  logic        i_sts_rdy,
  output logic        o_busy,
  output logic [15:0] o_job_cnt
);

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  job_t        r_job;
  aw_beat_t    r_aw_dat;
  w_beat_t     r_w_dat;
  logic [1:0]  r_sts_dat;
  logic        r_bresp_err;
  logic [15:0] r_job_cnt;
  logic [63:0] w_wdata;
  logic        w_timeout_hit;
  b_beat_t     w_b;

  logic r_job_rdy, r_aw_vld, r_w_vld, r_b_rdy, r_done_rdy, r_sts_vld, r_busy;
  logic w_job_rdy_nxt, w_aw_vld_nxt, w_w_vld_nxt, w_b_rdy_nxt;
  logic w_done_rdy_nxt, w_sts_vld_nxt, w_busy_nxt;

  // done payload and response id carry nothing this block acts on
  logic w_unused;
  assign w_unused = ^{i_done_dat, w_b.id, TIMEOUT_CYC};

  assign w_b = b_beat_t'(i_b_dat);

`ifdef DMA_CFG_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  logic [WdW-1:0] r_wd_cnt;

  // Watchdog: counts cycles spent in WAIT_DONE, held at zero elsewhere
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd_cnt <= '0;
    end else if (r_state != ST_WAIT_DONE) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WdW'(1);
    end
  end

  // A done_vld in the expiry cycle wins, so the timeout only fires without it
  assign w_timeout_hit = (r_state == ST_WAIT_DONE) && !i_done_vld &&
                         (r_wd_cnt == WdW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Next-state and register-index selection
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_job_vld && r_job_rdy) begin
          w_state_nxt = ST_AW;
          w_idx_nxt   = REG_SRC;
        end
      end
      ST_AW: begin
        if (r_aw_vld && i_aw_rdy) w_state_nxt = ST_W;
      end
      ST_W: begin
        if (r_w_vld && i_w_rdy) w_state_nxt = ST_B;
      end
      ST_B: begin
        if (i_b_vld && r_b_rdy) begin
          if (r_idx == REG_START) begin
            w_state_nxt = ST_WAIT_DONE;
          end else begin
            w_state_nxt = ST_AW;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end
      end
      ST_WAIT_DONE: begin
        if ((i_done_vld && r_done_rdy) || w_timeout_hit) w_state_nxt = ST_STS;
      end
      ST_STS: begin
        if (r_sts_vld && i_sts_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    w_job_rdy_nxt  = (w_state_nxt == ST_IDLE);
    w_aw_vld_nxt   = (w_state_nxt == ST_AW);
    w_w_vld_nxt    = (w_state_nxt == ST_W);
    w_b_rdy_nxt    = (w_state_nxt == ST_B);
    w_done_rdy_nxt = (w_state_nxt == ST_WAIT_DONE);
    w_sts_vld_nxt  = (w_state_nxt == ST_STS);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  // Write data for the register being programmed; 32-bit fields zero-extend
  always_comb begin
    case (r_idx)
      REG_SRC: w_wdata = {32'h0, r_job.src};
      REG_DST: w_wdata = {32'h0, r_job.dst};
      REG_LEN: w_wdata = {32'h0, r_job.len};
      default: w_wdata = START_VAL;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_job_rdy  <= 1'b1;
      r_aw_vld   <= 1'b0;
      r_w_vld    <= 1'b0;
      r_b_rdy    <= 1'b0;
      r_done_rdy <= 1'b0;
      r_sts_vld  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_job_rdy  <= w_job_rdy_nxt;
      r_aw_vld   <= w_aw_vld_nxt;
      r_w_vld    <= w_w_vld_nxt;
      r_b_rdy    <= w_b_rdy_nxt;
      r_done_rdy <= w_done_rdy_nxt;
      r_sts_vld  <= w_sts_vld_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Datapath: job latch, beat payloads loaded on state entry, sticky flags and job counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx       <= 2'd0;
      r_job       <= '0;
      r_aw_dat    <= '0;
      r_w_dat     <= '0;
      r_sts_dat   <= 2'b00;
      r_bresp_err <= 1'b0;
      r_job_cnt   <= 16'h0;
    end else begin
      r_idx <= w_idx_nxt;
      if (r_state == ST_IDLE && w_state_nxt == ST_AW) begin
        r_job <= job_t'(i_job_dat);
      end
      if (r_state != ST_AW && w_state_nxt == ST_AW) begin
        r_aw_dat <= '{len: 8'd0, addr: reg_addr(w_idx_nxt, REG_STRIDE), id: AXI_ID};
      end
      if (r_state != ST_W && w_state_nxt == ST_W) begin
        r_w_dat <= '{wstrb: WSTRB, last: 1'b1, data: w_wdata};
      end
      if (r_state == ST_B && i_b_vld && r_b_rdy && w_b.resp != 2'b00) begin
        r_bresp_err <= 1'b1;
      end
      if (r_state != ST_STS && w_state_nxt == ST_STS) begin
        r_sts_dat <= {w_timeout_hit, r_bresp_err};
      end
      if (r_state == ST_STS && w_state_nxt == ST_IDLE) begin
        r_job_cnt   <= r_job_cnt + 16'd1;
        r_bresp_err <= 1'b0;
      end
    end
  end

  assign o_job_rdy  = r_job_rdy;
  assign o_aw_dat   = r_aw_dat;
  assign o_aw_vld   = r_aw_vld;
  assign o_w_dat    = r_w_dat;
  assign o_w_vld    = r_w_vld;
  assign o_b_rdy    = r_b_rdy;
  assign o_done_rdy = r_done_rdy;
  assign o_sts_dat  = r_sts_dat;
  assign o_sts_vld  = r_sts_vld;
  assign o_busy     = r_busy;
  assign o_job_cnt  = r_job_cnt;

endmodule
